// File: rtl/jk_seq_ctrl.sv
// Sequencer that drives a master-slave JK flip-flop for a commanded number of cycles.
// Define JK_SEQ_CHECK_EN to compare the flop's q against the expected value after each command.
module jk_seq_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic             q_fb,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    CHECK = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             j_q, j_d;
  logic             k_q, k_d;
  logic             done_q, done_d;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    j_d     = j_q;
    k_d     = k_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        j_d = 1'b0;
        k_d = 1'b0;
        if (cmd_valid) begin
          cnt_d = cmd_len;
          if (cmd_len != '0) begin
            state_d = EXEC;
            // The op encoding maps straight onto the flop inputs: op[1] is j, op[0] is k.
            j_d     = cmd_op[1];
            k_d     = cmd_op[0];
          end else begin
            state_d = CHECK;
            done_d  = 1'b1;
          end
        end
      end
      EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = CHECK;
          j_d     = 1'b0;
          k_d     = 1'b0;
          done_d  = 1'b1;
        end
      end
      CHECK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        j_d     = 1'b0;
        k_d     = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign j         = j_q;
  assign k         = k_q;
  assign done      = done_q;

`ifdef JK_SEQ_CHECK_EN
  logic exp_q_q, exp_q_d;
  logic err_q, err_d;

  // Expected q is resolved at acceptance from the sampled q_fb, so later input changes cannot disturb it.
  always_comb begin
    exp_q_d = exp_q_q;
    if (state_q == IDLE && cmd_valid) begin
      case (cmd_op)
        2'b00:   exp_q_d = q_fb;
        2'b01:   exp_q_d = 1'b0;
        2'b10:   exp_q_d = 1'b1;
        default: exp_q_d = q_fb ^ cmd_len[0];
      endcase
      if (cmd_len == '0) exp_q_d = q_fb;
    end
    err_d = err_q | ((state_q == CHECK) && (q_fb != exp_q_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      exp_q_q <= exp_q_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_q_fb;
  assign unused_q_fb = q_fb;
  assign err         = 1'b0;
`endif

endmodule
